// File: rtl/decoder_pkg.sv
// Shared types and default geometry for the min-sum decoder controller.
package decoder_pkg;

  localparam int unsigned N_V_DEF    = 44;
  localparam int unsigned N_C_DEF    = 12;
  localparam int unsigned E_DEF      = 147;
  localparam int unsigned N_ITER_DEF = 5;
  localparam int unsigned EDGE_IDX_W = 8;

  typedef enum logic [2:0] {
    StFetch,
    StLoad,
    StScan,
    StCheck,
    StRun,
    StDrain,
    StErr
  } ctrl_state_t;

  // Input stage + N_ITER layers + output layer.
  function automatic int unsigned pipe_lat(input int unsigned n_iter);
    return n_iter + 2;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth valid+tag shift register; the last stage is the aligned output.
module tag_delay_line #(
  parameter int unsigned Depth = 7,
  parameter int unsigned TagW  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [TagW-1:0] i_tag,
  output logic            o_valid,
  output logic [TagW-1:0] o_tag
);

  logic [Depth-1:0]           r_valid;
  logic [Depth-1:0][TagW-1:0] r_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid <= {r_valid[Depth-2:0], i_valid};
      r_tag   <= {r_tag[Depth-2:0], i_tag};
    end
  end

  assign o_valid = r_valid[Depth-1];
  assign o_tag   = r_tag[Depth-1];

endmodule

// File: rtl/decoder_ctrl.sv
// Decoder sequencer: builds the edge table from H, then admits and tags codewords.
module decoder_ctrl
  import decoder_pkg::*;
#(
  parameter int unsigned N_V    = N_V_DEF,
  parameter int unsigned N_C    = N_C_DEF,
  parameter int unsigned E      = E_DEF,
  parameter int unsigned N_ITER = N_ITER_DEF,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic [$clog2(N_C)-1:0]   o_h_row_addr,
  input  logic [N_V-1:0]           i_h_row_data,
  output logic                     o_edge_we,
  output logic [EDGE_IDX_W-1:0]    o_edge_idx,
  output logic [EDGE_IDX_W-1:0]    o_edge_vn,
  output logic [EDGE_IDX_W-1:0]    o_edge_cn,
  input  logic                     i_cfg_start,
  output logic                     o_cfg_done,
  output logic                     o_cfg_err,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [N_V-1:0]           i_in_cw,
  input  logic [TAG_W-1:0]         i_in_tag,
  output logic                     o_cw_load,
  output logic [N_V-1:0]           o_cw_out,
  output logic                     o_out_valid,
  output logic [TAG_W-1:0]         o_out_tag,
  output logic                     o_busy
);

  localparam int unsigned PIPE_LAT = pipe_lat(N_ITER);
  localparam int unsigned RowW     = $clog2(N_C);
  localparam int unsigned ColW     = $clog2(N_V);
  localparam int unsigned OccW     = $clog2(PIPE_LAT + 2);

  localparam logic [RowW-1:0]       RowLast   = RowW'(N_C - 1);
  localparam logic [ColW-1:0]       ColLast   = ColW'(N_V - 1);
  localparam logic [EDGE_IDX_W-1:0] EdgeTotal = EDGE_IDX_W'(E);

  ctrl_state_t             r_state;
  logic [RowW-1:0]         r_i;
  logic [ColW-1:0]         r_j;
  logic [N_V-1:0]          r_row;
  logic [EDGE_IDX_W-1:0]   r_count;
  logic                    r_ovf;
  logic [OccW-1:0]         r_occ;
  logic [RowW-1:0]         r_h_row_addr;
  logic                    r_edge_we;
  logic [EDGE_IDX_W-1:0]   r_edge_idx;
  logic [EDGE_IDX_W-1:0]   r_edge_vn;
  logic [EDGE_IDX_W-1:0]   r_edge_cn;
  logic                    r_cfg_done;
  logic                    r_cfg_err;
  logic                    r_in_ready;
  logic                    r_cw_load;
  logic [N_V-1:0]          r_cw_out;
  logic [TAG_W-1:0]        r_cw_tag;
  logic                    r_busy;

  logic                    w_accept;
  logic                    w_out_valid;
  logic [TAG_W-1:0]        w_out_tag;
  logic [OccW-1:0]         w_occ_next;

  // in_ready is only ever high in RUN, so it alone qualifies an accept.
  assign w_accept = i_in_valid & r_in_ready;

  always_comb begin
    w_occ_next = r_occ;
    if (w_accept && !w_out_valid) begin
      w_occ_next = r_occ + 1'b1;
    end else if (!w_accept && w_out_valid) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StFetch;
      r_i          <= '0;
      r_j          <= '0;
      r_row        <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_occ        <= '0;
      r_h_row_addr <= '0;
      r_edge_we    <= 1'b0;
      r_edge_idx   <= '0;
      r_edge_vn    <= '0;
      r_edge_cn    <= '0;
      r_cfg_done   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cw_load    <= 1'b0;
      r_cw_out     <= '0;
      r_cw_tag     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_edge_we <= 1'b0;
      r_cw_load <= w_accept;
      r_occ     <= w_occ_next;
      r_busy    <= (w_occ_next != '0);
      if (w_accept) begin
        r_cw_out <= i_in_cw;
        r_cw_tag <= i_in_tag;
      end
      unique case (r_state)
        StFetch: begin
          r_h_row_addr <= r_i;
          r_busy       <= 1'b1;
          r_state      <= StLoad;
        end
        StLoad: begin
          r_row   <= i_h_row_data;
          r_j     <= '0;
          r_busy  <= 1'b1;
          r_state <= StScan;
        end
        StScan: begin
          r_busy <= 1'b1;
          if (r_row[r_j]) begin
            if (r_count != EdgeTotal) begin
              r_edge_we  <= 1'b1;
              r_edge_idx <= r_count;
              r_edge_vn  <= EDGE_IDX_W'(r_j);
              r_edge_cn  <= EDGE_IDX_W'(r_i);
              r_count    <= r_count + 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
          if (r_j == ColLast) begin
            if (r_i == RowLast) begin
              r_state <= StCheck;
            end else begin
              r_i     <= r_i + 1'b1;
              r_state <= StFetch;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        StCheck: begin
          if (r_count == EdgeTotal && !r_ovf) begin
            r_cfg_done <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= StRun;
          end else begin
            r_cfg_err <= 1'b1;
            r_state   <= StErr;
          end
        end
        StRun: begin
          if (i_cfg_start) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StDrain;
          end
        end
        StDrain: begin
          r_busy <= 1'b1;
          if (r_occ == '0) begin
            r_cfg_done <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_state    <= StFetch;
          end
        end
        StErr: begin
          r_in_ready <= 1'b0;
        end
        default: r_state <= StErr;
      endcase
    end
  end

  tag_delay_line #(
    .Depth (PIPE_LAT),
    .TagW  (TAG_W)
  ) u_tag_delay_line (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (r_cw_load),
    .i_tag   (r_cw_tag),
    .o_valid (w_out_valid),
    .o_tag   (w_out_tag)
  );

  assign o_h_row_addr = r_h_row_addr;
  assign o_edge_we    = r_edge_we;
  assign o_edge_idx   = r_edge_idx;
  assign o_edge_vn    = r_edge_vn;
  assign o_edge_cn    = r_edge_cn;
  assign o_cfg_done   = r_cfg_done;
  assign o_cfg_err    = r_cfg_err;
  assign o_in_ready   = r_in_ready;
  assign o_cw_load    = r_cw_load;
  assign o_cw_out     = r_cw_out;
  assign o_out_valid  = w_out_valid;
  assign o_out_tag    = w_out_tag;
  assign o_busy       = r_busy;

endmodule

// File: doc/decoder_ctrl.md
Name: decoder_ctrl

Overview:
- Sequencing controller for the unrolled min-sum decoder pipeline (LLR input stage, N_ITER intermediate layers, output layer).
- After reset it scans the parity-check matrix row by row and streams the Tanner-graph edge list (variable node, check node) into the datapath's edge table.
- It then admits codewords through a valid/ready handshake and tracks each one through the fixed-latency pipeline with a tag, so results can be matched to inputs.
- It also handles drain-and-reconfigure requests.

Parameters:
- N_V, 44, variable nodes (H columns)
- N_C, 12, check nodes (H rows)
- E, 147, expected edge count (ones in H)
- N_ITER, 5, intermediate layers in datapath
- PIPE_LAT, N_ITER+2, cycles from cw_load to result valid at out_layer
- TAG_W, 4, codeword tag width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- h_row_addr  out  $clog2(N_C)  H ROM row address
- h_row_data  in  N_V  H ROM row; valid one cycle after address
- edge_we  out  1  edge table write strobe
- edge_idx  out  8  edge index
- edge_vn  out  8  variable node (H column)
- edge_cn  out  8  check node (H row)
- cfg_start  in  1  request drain and reconfiguration (level, sampled in RUN)
- cfg_done  out  1  edge table valid, pipeline usable
- cfg_err  out  1  edge count != E (sticky until reset)
- in_valid  in  1  codeword offered
- in_ready  out  1  controller accepts
- in_cw  in  N_V  hard-decision codeword
- in_tag  in  TAG_W  codeword tag
- cw_load  out  1  datapath capture strobe
- cw_out  out  N_V  registered codeword to in_to_llr
- out_valid  out  1  out_layer result valid this cycle
- out_tag  out  TAG_W  tag of that result
- busy  out  1  configuring, or occupancy != 0

Behaviour:
- Reset (rst=0): all outputs 0; state FETCH; row counter i=0; column counter j=0; edge counter 0; occupancy 0; tag pipe cleared.
- All outputs are registered.
- FSM states: FETCH, LOAD, SCAN, CHECK, RUN, DRAIN, ERR.
- FETCH: h_row_addr=i. Next state LOAD.
- LOAD: latch h_row_data into row register. j=0. Next state SCAN.
- SCAN: one column per cycle.
  - If row[j]=1 and edge count<E: edge_we=1, edge_idx=count, edge_vn=j, edge_cn=i (next cycle); count+1.
  - If row[j]=1 and edge count==E: no write; set overflow flag.
  - At j=N_V-1: if i==N_C-1, go to CHECK; else i+1 and go to FETCH.
  - Row cost is N_V+2 cycles.
- CHECK: if count==E and no overflow, go to RUN with cfg_done=1. Otherwise go to ERR with cfg_err=1.
- cfg_done rises exactly N_C*(N_V+2)+1 rising edges after rst deasserts (553 at defaults).
- ERR: in_ready=0 and no edge writes until reset.
- RUN: in_ready=1 unless cfg_start=1.
  - Accept on in_valid&&in_ready: next cycle cw_load=1 for one cycle, cw_out=in_cw, and the tag enters a PIPE_LAT-deep shift pipe with a valid bit.
  - out_valid and out_tag appear exactly PIPE_LAT cycles after the cw_load cycle.
  - Back-to-back accepts are allowed every cycle.
  - No output backpressure; the pipeline is free-running.
- Occupancy counter:
  - +1 on accept, -1 on out_valid.
  - Simultaneous accept and out_valid: unchanged.
  - Never exceeds PIPE_LAT+1.
- cfg_start=1 in RUN: in_ready=0 that cycle; go to DRAIN.
- DRAIN: in_ready=0. When occupancy==0: cfg_done=0, clear counters, go to FETCH.
- in_valid in any non-RUN state is ignored (not accepted).
- edge_we and cw_load are never both asserted.
- Reset mid-operation: everything clears immediately. In-flight tags are discarded and no out_valid is produced for them. Configuration restarts automatically on rst release.

Decomposition:
- Shared package decoder_pkg holds:
  - FSM state enum (ctrl_state_t)
  - default N_V/N_C/E/N_ITER constants
  - EDGE_IDX_W=8
  - PIPE_LAT derivation function
- One sub-module is natural: tag_delay_line (PIPE_LAT-deep valid+tag shift register with async active-low reset). It is reused later for output alignment.

Test Plan:
- Default H (147 ones) → exactly 147 edge_we pulses, edge_idx 0..146 ascending in row-major order; cfg_done=1 at edge 553; cfg_err=0.
- H with 148 ones → 147 writes only; cfg_err=1, cfg_done=0; in_ready stays 0 for 100 cycles with in_valid=1.
- H with 146 ones → cfg_err=1 at edge 553; no accepts.
- Single accept of tag 3 after cfg_done → cw_load 1 cycle later; out_valid=1 with out_tag=3 exactly 7 cycles after cw_load; busy returns to 0 the cycle after.
- 10 back-to-back accepts, tags 0..9 → 10 consecutive out_valid cycles, tags 0..9 in order; occupancy peaks at 7 or 8.
- cfg_start with 3 in flight → in_ready=0 immediately; 3 out_valid pulses drain; then cfg_done=0, fresh 147-write scan, cfg_done=1 again.
- rst=0 during cycle 2 of a burst → all outputs 0 asynchronously; no out_valid for in-flight tags; after release, new scan completes at edge 553.
